// File: rtl/cp0_reg_pkg.sv
// Shared CP0 constants: register numbers, exception codes and reset/mask values.
package cp0_reg_pkg;
  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  localparam logic [4:0] EXC_INT   = 5'h00;
  localparam logic [4:0] EXC_ADEL  = 5'h04;
  localparam logic [4:0] EXC_ADES  = 5'h05;
  localparam logic [4:0] EXC_SYS   = 5'h08;
  localparam logic [4:0] EXC_BREAK = 5'h09;
  localparam logic [4:0] EXC_RI    = 5'h0A;
  localparam logic [4:0] EXC_OV    = 5'h0C;
  localparam logic [4:0] EXC_NONE  = 5'h10;
  localparam logic [4:0] EXC_ERET  = 5'h11;

  localparam logic [31:0] EXC_ADDR     = 32'hBFC0_0380;
  localparam logic [31:0] STATUS_RST   = 32'h0040_0000;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction
endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count advances every second cycle, TI latches on a match.
module cp0_timer
  import cp0_reg_pkg::*;
(
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst_n,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic        ti_clr,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);
  logic half;

  always_ff @(posedge cpu_clk_50M) begin
    if (!cpu_rst_n) begin
      half    <= 1'b0;
      count   <= '0;
      compare <= '0;
      ti      <= 1'b0;
    end else begin
      half <= ~half;
      if (we && waddr == CP0_COUNT) count <= wdata;
      else if (half)                count <= count + 32'd1;
      if (we && waddr == CP0_COMPARE) compare <= wdata;
      // a Compare write beats a coincident match
      if (ti_clr)                                ti <= 1'b0;
      else if (count == compare && compare != 0) ti <= 1'b1;
    end
  end
endmodule

// File: rtl/cp0_reg.sv
// CP0 register file: MFC0/MTC0 access, interrupt sampling, exception and ERET commit.
module cp0_reg
  import cp0_reg_pkg::*;
(
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst_n,
  input  logic        cp0_re_i,
  input  logic [4:0]  cp0_raddr_i,
  output logic [31:0] cp0_data_o,
  input  logic        cp0_we_i,
  input  logic [4:0]  cp0_waddr_i,
  input  logic [31:0] cp0_wdata_i,
  input  logic [5:0]  int_i,
  input  logic        inst_valid_i,
  input  logic [4:0]  exccode_i,
  input  logic [31:0] pc_i,
  input  logic        in_delay_i,
  input  logic [31:0] badvaddr_i,
  output logic        flush_o,
  output logic [31:0] cp0_excaddr_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic        timer_int_o
);
  logic [31:0] badvaddr, status, epc, count, compare, cause, rdata;
  logic        bd, ti;
  logic [7:0]  ip;
  logic [4:0]  exc_code;
  logic        int_pend, is_exc, is_eret, we_eff;
  logic [4:0]  code;

  assign cause = {bd, ti, 14'b0, ip, 1'b0, exc_code, 2'b00};

  assign int_pend = status[0] && !status[1] && ((ip & status[15:8]) != 8'h00);
  assign code     = (exccode_i == EXC_NONE && inst_valid_i && int_pend) ? EXC_INT : exccode_i;
  assign is_eret  = (code == EXC_ERET);
  assign is_exc   = (code != EXC_NONE) && !is_eret;
  assign we_eff   = cp0_we_i && !is_exc && !is_eret;

  cp0_timer u_timer (
    .cpu_clk_50M (cpu_clk_50M),
    .cpu_rst_n   (cpu_rst_n),
    .we          (we_eff),
    .waddr       (cp0_waddr_i),
    .wdata       (cp0_wdata_i),
    .ti_clr      (we_eff && cp0_waddr_i == CP0_COMPARE),
    .count       (count),
    .compare     (compare),
    .ti          (ti)
  );

  always_ff @(posedge cpu_clk_50M) begin
    if (!cpu_rst_n) begin
      badvaddr <= '0;
      status   <= STATUS_RST;
      epc      <= '0;
      bd       <= 1'b0;
      ip       <= '0;
      exc_code <= '0;
    end else begin
      ip[7:2] <= {int_i[5] | ti, int_i[4:0]};
      if (we_eff) begin
        case (cp0_waddr_i)
          CP0_STATUS: status  <= (status & ~STATUS_WMASK) | (cp0_wdata_i & STATUS_WMASK);
          CP0_CAUSE:  ip[1:0] <= cp0_wdata_i[9:8];
          CP0_EPC:    epc     <= cp0_wdata_i;
          default: ;
        endcase
      end
      if (is_exc) begin
        // nested exceptions keep the original return point
        if (!status[1]) begin
          epc <= in_delay_i ? pc_i - 32'd4 : pc_i;
          bd  <= in_delay_i;
        end
        status[1] <= 1'b1;
        exc_code  <= code;
        if (is_addr_exc(code)) badvaddr <= badvaddr_i;
      end
      if (is_eret) status[1] <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    case (cp0_raddr_i)
      CP0_BADVADDR: rdata = badvaddr;
      CP0_COUNT:    rdata = count;
      CP0_COMPARE:  rdata = compare;
      CP0_STATUS:   rdata = status;
      CP0_CAUSE:    rdata = cause;
      CP0_EPC:      rdata = epc;
      default:      rdata = '0;
    endcase
  end

  assign cp0_data_o    = (cpu_rst_n && cp0_re_i) ? rdata : '0;
  assign flush_o       = cpu_rst_n && (is_exc || is_eret);
  assign cp0_excaddr_o = !flush_o ? '0 : (is_eret ? epc : EXC_ADDR);
  assign status_o      = cpu_rst_n ? status : '0;
  assign cause_o       = cpu_rst_n ? cause : '0;
  assign timer_int_o   = cpu_rst_n && ti;
endmodule
